// File: rtl/adder_share_arb.sv
// Round-robin arbiter that shares one external pipelined adder among N requesters,
// with per-requester credits, tag-routed responses and a post-reset drain window.
module adder_share_arb #(
  parameter int unsigned W    = 384,
  parameter int unsigned N    = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned CRED = 4,
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*W-1:0]  req_in0,
  input  logic [N*W-1:0]  req_in1,
  input  logic [N-1:0]    req_cin,
  output logic            add_v,
  output logic [W-1:0]    add_in0,
  output logic [W-1:0]    add_in1,
  output logic            add_cin,
  output logic [IW-1:0]   add_tag,
  input  logic            add_v_o,
  input  logic [W-1:0]    add_sum,
  input  logic            add_cout,
  input  logic [IW-1:0]   add_tag_o,
  output logic            rsp_valid,
  output logic [IW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_sum,
  output logic            rsp_cout,
  output logic            idle,
  output logic            err
);

  localparam int unsigned CW = $clog2(CRED + 1);
  localparam int unsigned DW = $clog2(LAT + 2);

  logic [IW-1:0] ptr, ptr_n;
  logic [CW-1:0] credit   [N];
  logic [CW-1:0] credit_n [N];
  logic [DW-1:0] drain_cnt, drain_n;
  logic [N-1:0]  elig, inc, dec;
  logic [IW-1:0] gnt_id, idx;
  logic          draining, found, acc, ret, tag_ok, tag_full, ret_bad, all_full;

  assign draining = (drain_cnt != '0);
  assign acc      = |(req_valid & req_ready);

  // Round-robin grant: first eligible requester scanning upward from ptr
  always_comb begin : arb
    elig      = '0;
    found     = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    req_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      elig[i] = req_valid[i] && (credit[i] != '0) && en && !draining;
    end
    for (int k = 0; k < int'(N); k++) begin
      idx = IW'((int'(ptr) + k) % int'(N));
      if (!found && elig[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    if (found) req_ready[gnt_id] = 1'b1;
  end

  // Returned results: out-of-range tags or returns to a full credit are protocol errors
  always_comb begin : ret_chk
    tag_ok   = ({1'b0, add_tag_o} < (IW+1)'(N));
    tag_full = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (add_tag_o == IW'(i) && credit[i] == CW'(CRED)) tag_full = 1'b1;
    end
    ret     = add_v_o && !draining;
    ret_bad = ret && (!tag_ok || tag_full);
  end

  always_comb begin : nxt
    ptr_n    = ptr;
    drain_n  = draining ? drain_cnt - DW'(1) : drain_cnt;
    all_full = 1'b1;
    inc      = '0;
    dec      = '0;
    for (int i = 0; i < int'(N); i++) begin
      credit_n[i] = credit[i];
      dec[i] = acc && (gnt_id == IW'(i));
      inc[i] = ret && !ret_bad && (add_tag_o == IW'(i));
      if (dec[i] && !inc[i])      credit_n[i] = credit[i] - CW'(1);
      else if (inc[i] && !dec[i]) credit_n[i] = credit[i] + CW'(1);
      if (credit_n[i] != CW'(CRED)) all_full = 1'b0;
    end
    if (acc) ptr_n = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      drain_cnt <= DW'(LAT + 1);
      for (int i = 0; i < int'(N); i++) credit[i] <= CW'(CRED);
      add_v     <= 1'b0;
      add_in0   <= '0;
      add_in1   <= '0;
      add_cin   <= 1'b0;
      add_tag   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      err       <= 1'b0;
      idle      <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      drain_cnt <= drain_n;
      credit    <= credit_n;
      add_v     <= acc;
      if (acc) begin
        add_in0 <= req_in0[int'(gnt_id)*W +: W];
        add_in1 <= req_in1[int'(gnt_id)*W +: W];
        add_cin <= req_cin[gnt_id];
        add_tag <= gnt_id;
      end
      rsp_valid <= ret;
      if (ret) begin
        rsp_id   <= add_tag_o;
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end
      err  <= err | ret_bad;
      idle <= all_full && !acc && !ret && (drain_n == '0);
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb: behavioural grant/credit model, modelled
// external adder, and a response monitor matching results against queued expectations.
module tb_adder_share_arb;

  localparam int unsigned W    = 384;
  localparam int unsigned N    = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned CRED = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned CKW  = W + 1;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [N-1:0]    req_valid, req_ready, req_cin;
  logic [N*W-1:0]  req_in0, req_in1;
  logic            add_v, add_cin, add_v_o, add_cout;
  logic [W-1:0]    add_in0, add_in1, add_sum;
  logic [IW-1:0]   add_tag, add_tag_o;
  logic            rsp_valid, rsp_cout, idle, err;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_sum;

  logic            drop_ret, inj_v;
  logic [IW-1:0]   inj_tag;
  logic [W-1:0]    inj_sum;

  always #5 clk = ~clk;

  adder_share_arb #(.W(W), .N(N), .LAT(LAT), .CRED(CRED)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1), .req_cin(req_cin),
    .add_v(add_v), .add_in0(add_in0), .add_in1(add_in1), .add_cin(add_cin), .add_tag(add_tag),
    .add_v_o(add_v_o), .add_sum(add_sum), .add_cout(add_cout), .add_tag_o(add_tag_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .idle(idle), .err(err)
  );

  // External adder: fixed LAT-deep pipeline, not reset; returns can be dropped or forged
  logic          pv [LAT];
  logic [IW-1:0] pt [LAT];
  logic [W:0]    ps [LAT];
  always @(posedge clk) begin
    pv[0] <= add_v;
    pt[0] <= add_tag;
    ps[0] <= {1'b0, add_in0} + {1'b0, add_in1} + CKW'(add_cin);
    for (int k = 1; k < int'(LAT); k++) begin
      pv[k] <= pv[k-1];
      pt[k] <= pt[k-1];
      ps[k] <= ps[k-1];
    end
  end
  assign add_v_o   = inj_v | (pv[LAT-1] & ~drop_ret);
  assign add_tag_o = inj_v ? inj_tag : pt[LAT-1];
  assign add_sum   = inj_v ? inj_sum : ps[LAT-1][W-1:0];
  assign add_cout  = inj_v ? 1'b0 : ps[LAT-1][W];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          cout;
    int            t;
  } rsp_t;
  rsp_t rsp_q[$];
  int   dut_log[$];

  int            m_ptr, m_drain;
  int            m_cred [N];
  bit            m_err, m_idle, e_iv, e_c;
  logic [IW-1:0] e_tag;
  logic [W-1:0]  e_a, e_b;

  // Reference model: spec-level arbitration, credits, drain window and expectations
  always @(negedge clk) begin : model
    logic [N-1:0] er;
    logic [W:0]   full;
    int           gid, tg, j;
    bit           found, ret, bad, all_full;
    if (rst) begin
      chk("rst_ready", CKW'(req_ready), CKW'(0));
      chk("rst_add_v", CKW'(add_v), CKW'(0));
      chk("rst_add_data", CKW'({add_in0[7:0], add_in1[7:0], add_cin, add_tag}), CKW'(0));
      chk("rst_rsp", CKW'({rsp_valid, rsp_id, rsp_cout, rsp_sum[7:0]}), CKW'(0));
      chk("rst_err_idle", CKW'({err, idle}), CKW'(0));
      m_ptr = 0; m_drain = LAT + 1; m_err = 0; m_idle = 0; e_iv = 0;
      for (int i = 0; i < int'(N); i++) m_cred[i] = CRED;
      rsp_q.delete();
    end else begin
      chk("add_v", CKW'(add_v), CKW'(e_iv));
      if (e_iv) begin
        chk("add_tag", CKW'(add_tag), CKW'(e_tag));
        chk("add_in0", CKW'(add_in0), CKW'(e_a));
        chk("add_in1", CKW'(add_in1), CKW'(e_b));
        chk("add_cin", CKW'(add_cin), CKW'(e_c));
      end
      chk("err", CKW'(err), CKW'(m_err));
      chk("idle", CKW'(idle), CKW'(m_idle));
      er = '0; found = 0; gid = 0;
      for (int k = 0; k < int'(N); k++) begin
        j = (m_ptr + k) % int'(N);
        if (!found && req_valid[j] && m_cred[j] > 0 && en && m_drain == 0) begin
          found = 1; gid = j;
        end
      end
      if (found) er[gid] = 1'b1;
      chk("req_ready", CKW'(req_ready), CKW'(er));
      for (int i = 0; i < int'(N); i++) if (req_valid[i] && req_ready[i]) dut_log.push_back(i);
      ret = add_v_o && m_drain == 0;
      tg  = int'(add_tag_o);
      bad = ret && (tg >= int'(N) || m_cred[tg] == int'(CRED));
      if (ret && inj_v) rsp_q.push_back('{add_tag_o, inj_sum, 1'b0, cyc + 1});
      if (bad) m_err = 1;
      e_iv = found;
      if (found) begin
        m_cred[gid]--;
        e_tag = IW'(gid);
        e_a   = req_in0[gid*W +: W];
        e_b   = req_in1[gid*W +: W];
        e_c   = req_cin[gid];
        full  = {1'b0, e_a} + {1'b0, e_b} + CKW'(e_c);
        if (!drop_ret) rsp_q.push_back('{IW'(gid), full[W-1:0], full[W], cyc + int'(LAT) + 2});
        m_ptr = (gid + 1) % int'(N);
      end
      if (ret && !bad) m_cred[tg]++;
      if (m_drain > 0) m_drain--;
      all_full = 1;
      for (int i = 0; i < int'(N); i++) if (m_cred[i] != int'(CRED)) all_full = 0;
      m_idle = all_full && !found && !ret && m_drain == 0;
    end
  end

  // Response monitor: every rsp_valid must match the oldest expectation, on time
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (!rst && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", CKW'(rsp_valid), CKW'(0));
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_id", CKW'(rsp_id), CKW'(e.id));
        chk("rsp_sum", CKW'(rsp_sum), CKW'(e.sum));
        chk("rsp_cout", CKW'(rsp_cout), CKW'(e.cout));
        chk("rsp_cycle", CKW'(cyc), CKW'(e.t));
      end
    end
  end

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int k = 0; k < int'(W / 32); k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      req_in0[i*W +: W] = rnd_w();
      req_in1[i*W +: W] = ($urandom_range(0, 3) == 0) ? ~rnd_w() : rnd_w();
    end
    req_cin = N'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (idle !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, CKW'(idle), CKW'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int cnt;
    rst = 1; en = 0; req_valid = '0; req_cin = '0; req_in0 = '0; req_in1 = '0;
    drop_ret = 0; inj_v = 0; inj_tag = '0; inj_sum = '0;
    repeat (4) step();
    rst = 0;

    // All requesters valid after reset: drain, then rotating grants
    dut_log.delete();
    en = 1; req_valid = '1;
    repeat (LAT + 1 + 6) step();
    for (int i = 0; i < 5; i++)
      chk("grant_order", CKW'(i < dut_log.size() ? dut_log[i] : -1), CKW'(exp_ord[i]));

    // Single requester streaming: accept and return collide at credit 1
    req_valid = 4'b0001;
    repeat (16) step();
    req_valid = '0;
    wait_idle("idle_after_stream");

    // Max operand plus one on requester 1: sum wraps to zero with carry out
    step();
    req_in0[1*W +: W] = '1;
    req_in1[1*W +: W] = W'(1);
    req_cin[1] = 1'b0;
    req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("idle_after_wrap");

    // Forged return for tag 3 at full credit
    @(posedge clk);
    #1 inj_v = 1; inj_tag = 2'd3; inj_sum = rnd_w();
    @(posedge clk);
    #1 inj_v = 0;
    repeat (3) step();
    chk("err_sticky", CKW'(err), CKW'(1));
    wait_idle("idle_after_forged");

    // Random traffic with en toggling
    for (int c = 0; c < 400; c++) begin
      step();
      req_valid = N'($urandom);
      en = ($urandom_range(0, 7) != 0);
    end
    en = 1; req_valid = '0;
    wait_idle("idle_after_random");

    // Results never returned: requester 2 stops at CRED accepts, others still served
    drop_ret = 1;
    dut_log.delete();
    req_valid = 4'b0100;
    repeat (10) step();
    cnt = 0;
    foreach (dut_log[i]) if (dut_log[i] == 2) cnt++;
    chk("credit_limit", CKW'(cnt), CKW'(CRED));
    dut_log.delete();
    req_valid = 4'b1111;
    repeat (3) step();
    cnt = 0;
    foreach (dut_log[i]) if (dut_log[i] != 2) cnt++;
    chk("others_granted", CKW'(cnt), CKW'(3));

    // Reset with operations in flight: nothing may come back, full credits after drain
    rst = 1; drop_ret = 0; req_valid = '0;
    step();
    rst = 0;
    repeat (LAT + 1) step();
    chk("idle_after_drain", CKW'(idle), CKW'(1));
    chk("err_cleared", CKW'(err), CKW'(0));

    for (int c = 0; c < 100; c++) begin
      step();
      req_valid = N'($urandom);
    end
    req_valid = '0;
    wait_idle("idle_final");
    chk("rsp_q_empty", CKW'(rsp_q.size()), CKW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
